// File: rtl/stuff_tx.sv
// stuff_tx: CAN-style serial frame transmitter with bit stuffing.
// Sends SOF, 11-bit identifier, RTR, IDE, r0, DLC, data field, an optional
// CRC-15 field and a recessive delimiter, one bit per bitPulse strobe.
// After five identical driven bits inside the stuffed region a complement
// stuff bit is inserted. Define STUFF_TX_CRC_EN to include the CRC-15 field;
// the default build omits it and the delimiter follows the data field.
module stuff_tx (
  input  logic        clk,
  input  logic        reset,
  input  logic        bitPulse,
  input  logic        start,
  input  logic        abort,
  input  logic [10:0] id,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  output logic        txBit,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SEND,
    STUFF,
    DELIM
  } stateT;

`ifdef STUFF_TX_CRC_EN
  localparam logic [6:0] CrcLen = 7'd15;
`else
  localparam logic [6:0] CrcLen = 7'd0;
`endif
  localparam logic [6:0] HdrLen = 7'd19;

  stateT       state, stateNxt;
  logic        txBitNxt, busyNxt, doneNxt;
  logic [6:0]  bitIdx, bitIdxNxt;
  logic [2:0]  runCnt, runCntNxt;
  logic        lastBit, lastBitNxt;

  // Latched frame fields; the payload is shifted out MSB first.
  logic [10:0] idReg;
  logic        rtrReg;
  logic [3:0]  dlcReg;
  logic [63:0] dataSh;

  logic        latchEn;
  logic        sendBit;
  logic        shiftData;
  logic        frameBit;
  logic        crcBit;
  logic [18:0] hdr;
  logic [4:0]  hdrSel;
  logic [6:0]  dataBits;
  logic [6:0]  dataEnd;
  logic [6:0]  frameLen;

  // Frame geometry: header, data field (0 for remote frames, dlc capped at 8 bytes), CRC.
  assign hdr      = {1'b0, idReg, rtrReg, 2'b00, dlcReg};
  assign hdrSel   = 5'd18 - bitIdx[4:0];
  assign dataBits = rtrReg    ? 7'd0  :
                    dlcReg[3] ? 7'd64 : {1'b0, dlcReg[2:0], 3'b000};
  assign dataEnd  = HdrLen + dataBits;
  assign frameLen = dataEnd + CrcLen;
  assign shiftData = sendBit && (bitIdx >= HdrLen) && (bitIdx < dataEnd);

  // Select the unstuffed frame bit addressed by bitIdx.
  always_comb begin
    if (bitIdx < HdrLen) begin
      frameBit = hdr[hdrSel];
    end else if (bitIdx < dataEnd) begin
      frameBit = dataSh[63];
    end else begin
      frameBit = crcBit;
    end
  end

  // Next-state and output logic; abort overrides any coincident bitPulse.
  // NOTE: every signal gets a default first so no path leaves a latch behind.
  always_comb begin
    stateNxt   = state;
    txBitNxt   = txBit;
    busyNxt    = busy;
    doneNxt    = 1'b0;
    bitIdxNxt  = bitIdx;
    runCntNxt  = runCnt;
    lastBitNxt = lastBit;
    latchEn    = 1'b0;
    sendBit    = 1'b0;
    if (state != IDLE && abort) begin
      stateNxt = IDLE;
      txBitNxt = 1'b1;
      busyNxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            latchEn   = 1'b1;
            stateNxt  = ARMED;
            busyNxt   = 1'b1;
            bitIdxNxt = 7'd0;
            runCntNxt = 3'd0;
          end
        end
        ARMED, SEND: begin
          if (bitPulse) begin
            if (bitIdx == frameLen) begin
              // Delimiter: outside the stuffed region, never counted in a run.
              txBitNxt = 1'b1;
              stateNxt = DELIM;
            end else begin
              sendBit    = 1'b1;
              txBitNxt   = frameBit;
              lastBitNxt = frameBit;
              bitIdxNxt  = bitIdx + 7'd1;
              if (runCnt != 3'd0 && frameBit == lastBit) begin
                runCntNxt = runCnt + 3'd1;
              end else begin
                runCntNxt = 3'd1;
              end
              stateNxt = (runCntNxt == 3'd5) ? STUFF : SEND;
            end
          end
        end
        STUFF: begin
          if (bitPulse) begin
            // Stuff bit starts a new run of length one; frame index is not advanced.
            txBitNxt   = ~lastBit;
            lastBitNxt = ~lastBit;
            runCntNxt  = 3'd1;
            stateNxt   = SEND;
          end
        end
        DELIM: begin
          if (bitPulse) begin
            doneNxt  = 1'b1;
            txBitNxt = 1'b1;
            busyNxt  = 1'b0;
            stateNxt = IDLE;
          end
        end
        default: begin
          stateNxt = IDLE;
          txBitNxt = 1'b1;
          busyNxt  = 1'b0;
        end
      endcase
    end
  end

  // State and control registers.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      txBit   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      bitIdx  <= 7'd0;
      runCnt  <= 3'd0;
      lastBit <= 1'b1;
    end else begin
      state   <= stateNxt;
      txBit   <= txBitNxt;
      busy    <= busyNxt;
      done    <= doneNxt;
      bitIdx  <= bitIdxNxt;
      runCnt  <= runCntNxt;
      lastBit <= lastBitNxt;
    end
  end

  // Frame field capture on start acceptance, payload shift while the data field is sent.
  // NOTE: these hold payload only and are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    if (latchEn) begin
      idReg  <= id;
      rtrReg <= rtr;
      dlcReg <= dlc;
      dataSh <= data;
    end else if (shiftData) begin
      dataSh <= {dataSh[62:0], 1'b0};
    end
  end

`ifdef STUFF_TX_CRC_EN
  logic [14:0] crcReg;
  logic        crcFb;
  logic        crcUpd;
  logic        crcShift;

  assign crcFb    = frameBit ^ crcReg[14];
  assign crcUpd   = sendBit && (bitIdx < dataEnd);
  assign crcShift = sendBit && (bitIdx >= dataEnd);
  assign crcBit   = crcReg[14];

  // CRC-15 over SOF..data, then shifted out MSB first during the CRC field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crcReg <= 15'd0;
    end else if (latchEn) begin
      crcReg <= 15'd0;
    end else if (crcUpd) begin
      crcReg <= {crcReg[13:0], 1'b0} ^ (crcFb ? 15'h4599 : 15'h0000);
    end else if (crcShift) begin
      crcReg <= {crcReg[13:0], 1'b0};
    end
  end
`else
  assign crcBit = 1'b1;
`endif

endmodule

// File: tb/tb_stuff_tx.sv
// tb_stuff_tx: directed and random frames for stuff_tx, compared against a
// bench-side frame builder, CRC-15 and bit-stuffing model. Works for both
// builds (STUFF_TX_CRC_EN defined or not).
module tb_stuff_tx;

`ifdef STUFF_TX_CRC_EN
  localparam int CRC_LEN = 15;
`else
  localparam int CRC_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        bitPulse;
  logic        start;
  logic        abort;
  logic [10:0] id;
  logic        rtr;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic        txBit;
  logic        busy;
  logic        done;

  int nCmp  = 0;
  int nFail = 0;

  stuff_tx dut (
    .clk      (clk),
    .reset    (reset),
    .bitPulse (bitPulse),
    .start    (start),
    .abort    (abort),
    .id       (id),
    .rtr      (rtr),
    .dlc      (dlc),
    .data     (data),
    .txBit    (txBit),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unstuffed frame (SOF..CRC), CRC-15, stuffed stream plus delimiter.
  task automatic buildExp(input logic [10:0] fId, input logic fRtr, input logic [3:0] fDlc,
                          input logic [63:0] fData, output int nS, output logic [127:0] s,
                          output int nU, output logic [127:0] u, output logic [14:0] crc);
    int nd;
    int run;
    logic last;
    logic fb;
    u = '0; s = '0; crc = '0;
    u[0] = 1'b0;
    for (int i = 0; i < 11; i++) u[1 + i] = fId[10 - i];
    u[12] = fRtr;
    u[13] = 1'b0;
    u[14] = 1'b0;
    for (int i = 0; i < 4; i++) u[15 + i] = fDlc[3 - i];
    nd = fRtr ? 0 : ((fDlc > 4'd8) ? 8 : int'(fDlc)) * 8;
    for (int i = 0; i < nd; i++) u[19 + i] = fData[63 - i];
    nU = 19 + nd;
    for (int i = 0; i < nU; i++) begin
      fb  = u[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    for (int i = 0; i < CRC_LEN; i++) u[nU + i] = crc[14 - i];
    nU = nU + CRC_LEN;
    run = 0; last = 1'b0; nS = 0;
    for (int i = 0; i < nU; i++) begin
      s[nS] = u[i]; nS++;
      if (run > 0 && u[i] == last) run++;
      else begin run = 1; last = u[i]; end
      if (run == 5) begin
        s[nS] = ~u[i]; nS++;
        last = ~u[i]; run = 1;
      end
    end
    s[nS] = 1'b1; nS++;
  endtask

  // Remove stuff bits from a captured stream (delimiter excluded); count bad stuff bits.
  task automatic destuff(input logic [127:0] s, input int n, output logic [127:0] d,
                         output int nd, output int serr);
    int run;
    logic last;
    run = 0; last = 1'b0; d = '0; nd = 0; serr = 0;
    for (int i = 0; i < n - 1; i++) begin
      if (run == 5) begin
        if (s[i] === last) serr++;
        run = 1; last = s[i];
      end else begin
        d[nd] = s[i]; nd++;
        if (run > 0 && s[i] === last) run++;
        else begin run = 1; last = s[i]; end
      end
    end
  endtask

  // Start a frame, then pulse with a gap cycle until done (bounded to 200 pulses).
  task automatic runFrame(input logic [10:0] fId, input logic fRtr, input logic [3:0] fDlc,
                          input logic [63:0] fData, input bit coinc, output int nBits,
                          output logic [127:0] bits, output bit sawDone, output int holdErr);
    nBits = 0; bits = '0; sawDone = 1'b0; holdErr = 0;
    @(negedge clk);
    id = fId; rtr = fRtr; dlc = fDlc; data = fData; start = 1'b1; bitPulse = coinc;
    @(negedge clk);
    start = 1'b0; bitPulse = 1'b0;
    id = ~fId; rtr = ~fRtr; dlc = ~fDlc; data = ~fData;
    check("armed_busy", 128'(busy), 128'(1));
    if (coinc) check("coinc_not_consumed", 128'(txBit), 128'(1));
    for (int k = 0; k < 200 && !sawDone; k++) begin
      bitPulse = 1'b1;
      start = (k == 3);
      @(negedge clk);
      bitPulse = 1'b0;
      start = 1'b0;
      if (done === 1'b1) begin
        sawDone = 1'b1;
        check("done_txbit", 128'(txBit), 128'(1));
        check("done_busy", 128'(busy), 128'(0));
      end else begin
        bits[nBits] = txBit;
        nBits++;
      end
      @(negedge clk);
      if (!sawDone && txBit !== bits[nBits - 1]) holdErr++;
      if (sawDone && done !== 1'b0) holdErr++;
    end
  endtask

  // Full frame with model comparison; returns raw and destuffed streams.
  task automatic frameTest(input logic [10:0] fId, input logic fRtr, input logic [3:0] fDlc,
                           input logic [63:0] fData, input bit coinc, output int nBits,
                           output logic [127:0] bits, output logic [127:0] dst, output int nDst);
    int holdErr, serr, expN, expNu;
    bit sawDone;
    logic [127:0] expBits, expUn;
    logic [14:0] expCrc;
    logic [14:0] gotCrc;
    runFrame(fId, fRtr, fDlc, fData, coinc, nBits, bits, sawDone, holdErr);
    buildExp(fId, fRtr, fDlc, fData, expN, expBits, expNu, expUn, expCrc);
    check("frame_len", 128'(nBits), 128'(expN));
    check("frame_bits", bits, expBits);
    check("frame_done", 128'(sawDone), 128'(1));
    check("frame_hold", 128'(holdErr), 128'(0));
    destuff(bits, nBits, dst, nDst, serr);
    check("stuff_bits", 128'(serr), 128'(0));
    check("destuffed", dst, expUn);
    gotCrc = '0;
    for (int i = 0; i < 15 && CRC_LEN == 15; i++) gotCrc[14 - i] = dst[expNu - 15 + i];
    if (CRC_LEN == 15) check("crc", 128'(gotCrc), 128'(expCrc));
  endtask

  logic [127:0] bits, dst;
  int           nBits, nDst;
  logic [6:0]   first7;
  logic [63:0]  rData;
  bit           doneSeen;

  initial begin
    reset = 1'b1; bitPulse = 1'b0; start = 1'b0; abort = 1'b0;
    id = '0; rtr = 1'b0; dlc = '0; data = '0;
    repeat (3) @(negedge clk);
    check("reset_txbit", 128'(txBit), 128'(1));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    reset = 1'b0;

    // All-zero identifier: stuff 1 after five dominant bits, coincident start/bitPulse.
    frameTest(11'h000, 1'b0, 4'h0, 64'h0, 1'b1, nBits, bits, dst, nDst);
    first7 = {bits[0], bits[1], bits[2], bits[3], bits[4], bits[5], bits[6]};
    check("id000_first7", 128'(first7), 128'(7'b0000010));

    // All-ones identifier: stuff 0 after five recessive bits.
    frameTest(11'h7FF, 1'b0, 4'h0, 64'h0, 1'b0, nBits, bits, dst, nDst);
    first7 = {bits[0], bits[1], bits[2], bits[3], bits[4], bits[5], bits[6]};
    check("id7ff_first7", 128'(first7), 128'(7'b0111110));

    // Remote frame with dlc=8: no data field.
    frameTest(11'h2A5, 1'b1, 4'h8, 64'hDEAD_BEEF_0123_4567, 1'b0, nBits, bits, dst, nDst);
    check("rtr_unstuffed_len", 128'(nDst), 128'(19 + CRC_LEN));
    check("rtr_delim", 128'(bits[nBits - 1]), 128'(1));
    check("rtr_dlc_field", 128'({dst[15], dst[16], dst[17], dst[18]}), 128'(4'h8));

    // dlc=15 with all-ones payload: raw DLC sent, 64 data bits.
    frameTest(11'h123, 1'b0, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, nBits, bits, dst, nDst);
    check("dlcf_field", 128'({dst[15], dst[16], dst[17], dst[18]}), 128'(4'hF));
    check("dlcf_data", 128'(dst[82:19]), 128'(64'hFFFF_FFFF_FFFF_FFFF));
    check("dlcf_len", 128'(nDst), 128'(83 + CRC_LEN));

    // Short mixed payload.
    frameTest(11'h555, 1'b0, 4'h3, 64'h0F83_E000_0000_0000, 1'b0, nBits, bits, dst, nDst);

    // Abort after the 10th bitPulse, coincident with a pulse.
    @(negedge clk);
    id = 11'h000; rtr = 1'b0; dlc = 4'h0; data = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      bitPulse = 1'b1; @(negedge clk);
      bitPulse = 1'b0; @(negedge clk);
    end
    check("abort_pre_txbit", 128'(txBit), 128'(0));
    abort = 1'b1; bitPulse = 1'b1;
    @(negedge clk);
    abort = 1'b0; bitPulse = 1'b0;
    check("abort_txbit", 128'(txBit), 128'(1));
    check("abort_busy", 128'(busy), 128'(0));
    doneSeen = (done === 1'b1);
    repeat (5) begin
      bitPulse = 1'b1; @(negedge clk);
      bitPulse = 1'b0;
      if (done === 1'b1) doneSeen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", 128'(doneSeen), 128'(0));
    check("abort_idle_txbit", 128'(txBit), 128'(1));
    frameTest(11'h3C1, 1'b0, 4'h2, 64'hA5C3_0000_0000_0000, 1'b0, nBits, bits, dst, nDst);

    // Reset mid-frame: immediate drop, start ignored while reset is held.
    @(negedge clk);
    id = 11'h000; rtr = 1'b0; dlc = 4'h1; data = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      bitPulse = 1'b1; @(negedge clk);
      bitPulse = 1'b0; @(negedge clk);
    end
    check("rst_pre_txbit", 128'(txBit), 128'(0));
    #2 reset = 1'b1;
    #1;
    check("rst_async_txbit", 128'(txBit), 128'(1));
    check("rst_async_busy", 128'(busy), 128'(0));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_start_ignored", 128'(busy), 128'(0));
    check("rst_no_done", 128'(done), 128'(0));
    frameTest(11'h0F0, 1'b0, 4'h1, 64'h7E00_0000_0000_0000, 1'b0, nBits, bits, dst, nDst);

    // Random frames with stuffing-prone byte patterns.
    for (int f = 0; f < 200; f++) begin
      for (int b = 0; b < 8; b++) begin
        case ($urandom_range(0, 2))
          0:       rData[63 - 8*b -: 8] = 8'h00;
          1:       rData[63 - 8*b -: 8] = 8'hFF;
          default: rData[63 - 8*b -: 8] = 8'($urandom);
        endcase
      end
      frameTest(11'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                rData, ($urandom_range(0, 3) == 0), nBits, bits, dst, nDst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/stuff_tx.md
STUFF_TX -- requirements
Module: stuff_tx

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port bitPulse, input, 1 bit: one-cycle strobe, one per CAN bit time; advances transmission by one bit.
REQ-004 SHALL have port start, input, 1 bit: request to transmit one frame; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit: terminate the frame in progress.
REQ-006 SHALL have port id, input, 11 bits: standard identifier, sent MSB first.
REQ-007 SHALL have port rtr, input, 1 bit: remote-frame flag.
REQ-008 SHALL have port dlc, input, 4 bits: data length code, sent MSB first.
REQ-009 SHALL have port data, input, 64 bits: payload; byte 0 is data[63:56]; bytes and bits sent MSB first.
REQ-010 SHALL have port txBit, output, 1 bit: serial CAN bit; recessive = 1.
REQ-011 SHALL have port busy, output, 1 bit: high from start acceptance until return to IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on normal frame completion.

Function
REQ-013 SHALL, in IDLE with start=1, latch id, rtr, dlc and data, and enter ARMED the next cycle with busy=1; inputs are ignored afterwards until IDLE.
REQ-014 SHALL ignore start when not in IDLE.
REQ-015 SHALL, when start and bitPulse coincide in IDLE, accept start and not consume the pulse.
REQ-016 SHALL, on each bitPulse in ARMED, SEND, STUFF or DELIM, register the next frame bit onto txBit on the following clock edge; txBit is otherwise held.
REQ-017 SHALL send the unstuffed frame bits in this order: SOF=0, id[10:0], rtr, IDE=0, r0=0, dlc[3:0], data field, CRC field (REQ-039), delimiter=1.
REQ-018 SHALL size the data field as 0 bits when rtr=1, and otherwise as 8*min(dlc,8) bits; dlc values 9..15 give 64 bits while the DLC field still carries the raw dlc.
REQ-019 SHALL track the last driven bit value and a 3-bit run count; stuff bits count toward the run.
REQ-020 SHALL, after 5 consecutive identical driven bits within the stuffed region (SOF through the last bit before the delimiter), enter STUFF and drive the complement on the next bitPulse, without advancing the frame-bit index; the run count then resets to 1 with the new value.
REQ-021 SHALL insert a stuff bit after the final stuffed-region bit when that bit completes a run of 5, before the delimiter.
REQ-022 SHALL never stuff the delimiter and never count it toward a run.
REQ-023 SHALL use a 7-bit frame-bit index (maximum 19+64+15 = 98 unstuffed bits).
REQ-024 SHALL, on the first bitPulse after the delimiter is driven, pulse done for one cycle, set txBit=1 and busy=0, and return to IDLE.
REQ-025 SHALL, on abort=1 in any non-IDLE state, return to IDLE on the next edge with txBit=1, busy=0 and no done pulse; abort takes priority over a coincident bitPulse.
REQ-026 SHALL implement the state machine IDLE -> ARMED -> SEND <-> STUFF -> DELIM -> IDLE, with abort leading from any non-IDLE state to IDLE.

Reset
REQ-027 SHALL, while reset=1, immediately force state=IDLE, txBit=1, busy=0, done=0, run count=0, frame-bit index=0 and CRC register=0.
REQ-028 SHALL, when reset is asserted mid-frame, drop the frame with no done pulse, and accept a new start only after reset is released.
REQ-029 SHALL leave the latched frame fields at their don't-care values after reset.

Configuration
REQ-030 SHALL, with macro STUFF_TX_CRC_EN defined, compute a CRC-15 (polynomial 0x4599, initial value 0) over the unstuffed bits from SOF through the end of the data field.
REQ-031 SHALL, with STUFF_TX_CRC_EN defined, send the 15 CRC bits MSB first after the data field as part of the stuffed region.
REQ-032 SHALL, with STUFF_TX_CRC_EN undefined, omit the CRC logic so that the delimiter immediately follows the data field.
REQ-039 SHALL treat the CRC field as 15 bits when STUFF_TX_CRC_EN is defined, and as absent otherwise.

Verification
REQ-033 SHALL verify: id=0x000, rtr=0, dlc=0 -> first six transmitted bits are 0,0,0,0,0,1 (stuff), followed by 0.
REQ-034 SHALL verify: id=0x7FF, rtr=0, dlc=0 -> first seven transmitted bits are 0,1,1,1,1,1,0 (stuff).
REQ-035 SHALL verify: rtr=1, dlc=8, CRC enabled -> 34 unstuffed bits, then delimiter=1, then done one pulse later, with no data bits sent.
REQ-036 SHALL verify: dlc=4'hF, data=64'hFFFF_FFFF_FFFF_FFFF -> DLC field is 1111, 64 data bits are sent, and every sixth bit in the run is a stuff 0.
REQ-037 SHALL verify: abort after the 10th bitPulse -> txBit=1 and busy=0 one cycle later, no done, and a later start is accepted.
REQ-038 SHALL verify: 200 random frames with CRC enabled -> destuffed stream and CRC match the bench's reference model.
